// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display data/drive bundle for seg7_scan_driver
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_done;

    modport master (output value, dp_in, input an, seg, dp, frame_done);
    modport slave  (input value, dp_in, output an, seg, dp, frame_done);
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed seven-segment scan driver with blanking and frame-latched value
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 16,
    parameter bit LZ_SUPPRESS  = 1'b0
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              scan_clk,
    seg7_scan_driver_if.slave disp
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

    state_t                  r_state;
    logic [2:0]              r_sync;
    logic [7:0]              r_cnt;
    logic [IDX_W-1:0]        r_index;
    logic [4*NUM_DIGITS-1:0] r_shadow_val;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic                    r_frame_done;

    state_t                  w_state_nxt;
    logic [7:0]              w_cnt_nxt;
    logic [IDX_W-1:0]        w_index_nxt;
    logic                    w_load;
    logic                    w_frame_done_nxt;
    logic                    w_tick;
    logic [3:0]              w_digit;
    logic                    w_upper_zero;
    logic                    w_lz_blank;
    logic [NUM_DIGITS-1:0]   w_an_nxt;
    logic [6:0]              w_seg_nxt;
    logic                    w_dp_nxt;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0:    hex_to_seg = 7'h40;
            4'h1:    hex_to_seg = 7'h79;
            4'h2:    hex_to_seg = 7'h24;
            4'h3:    hex_to_seg = 7'h30;
            4'h4:    hex_to_seg = 7'h19;
            4'h5:    hex_to_seg = 7'h12;
            4'h6:    hex_to_seg = 7'h02;
            4'h7:    hex_to_seg = 7'h78;
            4'h8:    hex_to_seg = 7'h00;
            4'h9:    hex_to_seg = 7'h10;
            4'hA:    hex_to_seg = 7'h08;
            4'hB:    hex_to_seg = 7'h03;
            4'hC:    hex_to_seg = 7'h46;
            4'hD:    hex_to_seg = 7'h21;
            4'hE:    hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // scan_clk is asynchronous: two flops resolve metastability, the third finds the rising edge
    assign w_tick = r_sync[1] & ~r_sync[2];

    assign w_digit      = r_shadow_val[{r_index, 2'b00} +: 4];
    assign w_upper_zero = ((r_shadow_val >> {r_index, 2'b00}) == '0);
    assign w_lz_blank   = LZ_SUPPRESS && (r_index != '0) && w_upper_zero;

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_index_nxt      = r_index;
        w_load           = 1'b0;
        w_frame_done_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_load      = 1'b1;
                    w_index_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_BLANK;
                end
            end
            S_BLANK: begin
                // ticks arriving here are dropped on purpose; the scan period dwarfs the gap
                if (r_cnt == 8'(BLANK_CYCLES - 1)) begin
                    w_state_nxt = S_DRIVE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_DRIVE: begin
                if (w_tick) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_BLANK;
                    if (r_index == IDX_W'(NUM_DIGITS - 1)) begin
                        w_index_nxt      = '0;
                        w_load           = 1'b1;
                        w_frame_done_nxt = 1'b1;
                    end else begin
                        w_index_nxt = r_index + IDX_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // index and shadow never change on a transition into DRIVE, so current values decode the next digit
    always_comb begin
        w_an_nxt  = '1;
        w_seg_nxt = 7'h7F;
        w_dp_nxt  = 1'b1;
        if (w_state_nxt == S_DRIVE) begin
            w_an_nxt  = ~(NUM_DIGITS'(1) << r_index);
            w_seg_nxt = w_lz_blank ? 7'h7F : hex_to_seg(w_digit);
            w_dp_nxt  = ~r_shadow_dp[r_index];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_sync       <= '0;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_index      <= '0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_an         <= '1;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_sync       <= {r_sync[1:0], scan_clk};
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_index      <= w_index_nxt;
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_dp         <= w_dp_nxt;
            r_frame_done <= w_frame_done_nxt;
            if (w_load) begin
                r_shadow_val <= disp.value;
                r_shadow_dp  <= disp.dp_in;
            end
        end
    end

    assign disp.an         = r_an;
    assign disp.seg        = r_seg;
    assign disp.dp         = r_dp;
    assign disp.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - bench for seg7_scan_driver, plain and leading-zero-suppressed instances
module tb_seg7_scan_driver;
    localparam int N     = 4;
    localparam int BLANK = 16;
    localparam int M_IDLE = 0, M_BLANK = 1, M_DRIVE = 2;

    logic clk_in   = 1'b0;
    logic rst_n    = 1'b0;
    logic scan_clk = 1'b0;

    seg7_scan_driver_if #(.NUM_DIGITS(N)) if0 ();
    seg7_scan_driver_if #(.NUM_DIGITS(N)) if1 ();

    seg7_scan_driver #(.NUM_DIGITS(N), .BLANK_CYCLES(BLANK), .LZ_SUPPRESS(1'b0)) dut0 (
        .clk_in(clk_in), .rst_n(rst_n), .scan_clk(scan_clk), .disp(if0));
    seg7_scan_driver #(.NUM_DIGITS(N), .BLANK_CYCLES(BLANK), .LZ_SUPPRESS(1'b1)) dut1 (
        .clk_in(clk_in), .rst_n(rst_n), .scan_clk(scan_clk), .disp(if1));

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int         m_mode = M_IDLE;
    int         m_left = 0;
    int         m_idx  = 0;
    int         m_cyc  = 0;
    bit         m_fd   = 1'b0;
    bit         m_prev = 1'b0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dpv = '0;
    int         m_tick_q[$];

    logic [11:0] log0[$];
    logic [11:0] log1[$];
    int          runlog[$];
    int          frun   = 0;
    int          fdcnt  = 0;
    logic [3:0]  prev0  = 4'hF;
    logic [3:0]  prev1  = 4'hF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A scan_clk rise seen at clock edge k is acted on by the scanner at edge k+2
    task automatic model_step();
        bit t;
        if (!rst_n) begin
            m_mode = M_IDLE; m_left = 0; m_idx = 0; m_fd = 1'b0;
            m_val = '0; m_dpv = '0; m_prev = 1'b0;
            m_tick_q.delete();
            return;
        end
        m_cyc++;
        t = (m_tick_q.size() > 0) && (m_tick_q[0] == m_cyc);
        if (t) void'(m_tick_q.pop_front());
        if (scan_clk && !m_prev) m_tick_q.push_back(m_cyc + 2);
        m_prev = scan_clk;
        m_fd = 1'b0;
        case (m_mode)
            M_IDLE: if (t) begin
                m_val = if0.value; m_dpv = if0.dp_in; m_idx = 0;
                m_left = BLANK; m_mode = M_BLANK;
            end
            M_BLANK: begin
                m_left--;
                if (m_left == 0) m_mode = M_DRIVE;
            end
            default: if (t) begin
                if (m_idx == N - 1) begin
                    m_fd = 1'b1; m_idx = 0; m_val = if0.value; m_dpv = if0.dp_in;
                end else begin
                    m_idx++;
                end
                m_left = BLANK; m_mode = M_BLANK;
            end
        endcase
    endtask

    function automatic bit lit();
        return rst_n && (m_mode == M_DRIVE);
    endfunction

    function automatic logic [3:0] e_an();
        if (!lit()) return 4'hF;
        return ~(4'd1 << m_idx);
    endfunction

    function automatic logic [6:0] e_seg(input bit lz);
        logic [3:0] dg;
        if (!lit()) return 7'h7F;
        dg = m_val[4*m_idx +: 4];
        if (lz && m_idx > 0 && (m_val >> (4*m_idx)) == 16'd0) return 7'h7F;
        return seg_tab[dg];
    endfunction

    function automatic logic e_dp();
        if (!lit()) return 1'b1;
        return ~m_dpv[m_idx];
    endfunction

    task automatic cmp(input string tag, input bit lz, input logic [3:0] an, input logic [6:0] seg,
                       input logic dp, input logic fd);
        int zeros;
        zeros = 0;
        chk({tag, "_an"},  an,  e_an());
        chk({tag, "_seg"}, seg, e_seg(lz));
        chk({tag, "_dp"},  dp,  e_dp());
        chk({tag, "_fd"},  fd,  rst_n ? m_fd : 1'b0);
        for (int i = 0; i < N; i++) if (an[i] == 1'b0) zeros++;
        chk({tag, "_onehot"}, zeros <= 1, 1'b1);
    endtask

    initial forever begin
        @(posedge clk_in);
        model_step();
    end

    initial forever begin
        @(negedge clk_in);
        cmp("dut0", 1'b0, if0.an, if0.seg, if0.dp, if0.frame_done);
        cmp("dut1", 1'b1, if1.an, if1.seg, if1.dp, if1.frame_done);
        if (if0.an != 4'hF && prev0 == 4'hF) begin
            log0.push_back({if0.an, if0.seg, if0.dp});
            runlog.push_back(frun);
        end
        if (if1.an != 4'hF && prev1 == 4'hF) log1.push_back({if1.an, if1.seg, if1.dp});
        frun  = (if0.an == 4'hF) ? frun + 1 : 0;
        prev0 = if0.an;
        prev1 = if1.an;
        if (if0.frame_done) fdcnt++;
    end

    function automatic logic [11:0] at0(input int i);
        return (i < log0.size()) ? log0[i] : 12'hFFF;
    endfunction
    function automatic logic [11:0] at1(input int i);
        return (i < log1.size()) ? log1[i] : 12'hFFF;
    endfunction
    function automatic int run_at(input int i);
        return (i < runlog.size()) ? runlog[i] : -1;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #3;
    endtask

    task automatic pulse();
        scan_clk = 1'b1; cyc(100);
        scan_clk = 1'b0; cyc(100);
    endtask

    task automatic set_in(input logic [15:0] v, input logic [3:0] d);
        if0.value = v; if0.dp_in = d;
        if1.value = v; if1.dp_in = d;
    endtask

    task automatic clear_logs();
        log0.delete(); log1.delete(); runlog.delete(); fdcnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cyc(3);
        rst_n = 1'b1; cyc(5);
    endtask

    initial begin
        set_in(16'h0000, 4'h0);
        rst_n = 1'b0; scan_clk = 1'b0;
        cyc(2);
        for (int i = 0; i < 6; i++) begin scan_clk = ~scan_clk; cyc(1); end
        chk("t1_rst_an",  if0.an, 4'hF);
        chk("t1_rst_seg", if0.seg, 7'h7F);
        chk("t1_rst_dp",  if0.dp, 1'b1);
        chk("t1_rst_fd",  if0.frame_done, 1'b0);
        rst_n = 1'b1; cyc(30);
        chk("t1_idle_an", if0.an, 4'hF);

        set_in(16'h1234, 4'h0);
        clear_logs();
        repeat (4) pulse();
        chk("t2_fd_before_wrap", fdcnt, 0);
        pulse();
        chk("t2_fd_after_wrap", fdcnt, 1);
        chk("t2_nlog", log0.size(), 5);
        chk("t2_d0", at0(0), {4'hE, 7'h19, 1'b1});
        chk("t2_d1", at0(1), {4'hD, 7'h30, 1'b1});
        chk("t2_d2", at0(2), {4'hB, 7'h24, 1'b1});
        chk("t2_d3", at0(3), {4'h7, 7'h79, 1'b1});
        chk("t2_blank1", run_at(1), 16);
        chk("t2_blank3", run_at(3), 16);
        chk("t2_blank_wrap", run_at(4), 16);

        pulse();
        set_in(16'hABCD, 4'h0);
        clear_logs();
        repeat (6) pulse();
        chk("t3_old_d2", at0(0), {4'hB, 7'h24, 1'b1});
        chk("t3_old_d3", at0(1), {4'h7, 7'h79, 1'b1});
        chk("t3_new_d0", at0(2), {4'hE, 7'h21, 1'b1});
        chk("t3_new_d1", at0(3), {4'hD, 7'h46, 1'b1});
        chk("t3_new_d2", at0(4), {4'hB, 7'h03, 1'b1});
        chk("t3_new_d3", at0(5), {4'h7, 7'h08, 1'b1});
        chk("t3_fd", fdcnt, 1);

        do_reset();
        set_in(16'h0050, 4'h0);
        clear_logs();
        repeat (4) pulse();
        chk("t4_lz_d0", at1(0), {4'hE, 7'h40, 1'b1});
        chk("t4_lz_d1", at1(1), {4'hD, 7'h12, 1'b1});
        chk("t4_lz_d2", at1(2), {4'hB, 7'h7F, 1'b1});
        chk("t4_lz_d3", at1(3), {4'h7, 7'h7F, 1'b1});
        chk("t4_nolz_d2", at0(2), {4'hB, 7'h40, 1'b1});
        chk("t4_nolz_d3", at0(3), {4'h7, 7'h40, 1'b1});
        do_reset();
        set_in(16'h0000, 4'h0);
        clear_logs();
        repeat (4) pulse();
        chk("t4_zero_d0", at1(0), {4'hE, 7'h40, 1'b1});
        chk("t4_zero_d1", at1(1), {4'hD, 7'h7F, 1'b1});
        chk("t4_zero_d2", at1(2), {4'hB, 7'h7F, 1'b1});
        chk("t4_zero_d3", at1(3), {4'h7, 7'h7F, 1'b1});

        do_reset();
        set_in(16'h1234, 4'h0);
        clear_logs();
        scan_clk = 1'b1; cyc(1000);
        scan_clk = 1'b0; cyc(20);
        chk("t5_held_ticks", log0.size(), 1);
        chk("t5_held_an", if0.an, 4'hE);
        scan_clk = 1'b1; cyc(3);
        scan_clk = 1'b0; cyc(3);
        scan_clk = 1'b1; cyc(3);
        scan_clk = 1'b0; cyc(100);
        chk("t5_blank_tick_an", if0.an, 4'hD);
        chk("t5_blank_tick_n", log0.size(), 2);
        rst_n = 1'b0;
        #1;
        chk("t5_async_an", if0.an, 4'hF);
        chk("t5_async_seg", if0.seg, 7'h7F);
        cyc(1);
        rst_n = 1'b1;
        cyc(20);
        chk("t5_idle_an", if0.an, 4'hF);
        pulse();
        chk("t5_restart_an", if0.an, 4'hE);

        do_reset();
        set_in(16'h1234, 4'b0100);
        clear_logs();
        repeat (4) pulse();
        chk("t6_dp_d0", at0(0), {4'hE, 7'h19, 1'b1});
        chk("t6_dp_d1", at0(1), {4'hD, 7'h30, 1'b1});
        chk("t6_dp_d2", at0(2), {4'hB, 7'h24, 1'b0});
        chk("t6_dp_d3", at0(3), {4'h7, 7'h79, 1'b1});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
